// File: rtl/ft_ctrl_pkg.sv
// Shared state encoding and defaults for the fault recovery controller.
// Optional fault logging (FT_FAULT_LOG_EN) is handled in fault_recovery_ctrl.
package ft_ctrl_pkg;

   localparam int          STATE_W          = 3;
   localparam int          CAUSE_W          = 4;
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

   typedef enum logic [STATE_W-1:0] {
      ST_NORMAL      = 3'd0,
      ST_FLUSH       = 3'd1,
      ST_RETRY       = 3'd2,
      ST_WAIT_COMMIT = 3'd3,
      ST_HALT        = 3'd4
   } state_e;

endpackage

// File: rtl/ft_fault_prio_enc.sv
// Fault priority encoder: bit 0 of fault_vec has the highest priority.
module ft_fault_prio_enc
   import ft_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] fault_vec,
   output logic               valid,
   output logic [CAUSE_W-1:0] index
);

   always_comb begin
      valid = |fault_vec;
      index = '0;
      // Scanning downwards lets the lowest set bit overwrite any higher one.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (fault_vec[i]) index = CAUSE_W'(i);
      end
   end

endmodule

// File: rtl/fault_recovery_ctrl.sv
// Fault recovery controller: gates writes on faults, flushes, retries from pc_saved, halts to a trap vector.
// Define FT_FAULT_LOG_EN to add the fault_total / sticky_src logging outputs.
module fault_recovery_ctrl
   import ft_ctrl_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter int               NUM_SRC      = 4,
   parameter int               MAX_RETRY    = 3,
   parameter int               FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0]  TRAP_VEC     = XLEN'(TRAP_VEC_DEFAULT)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] fault_vec,
   input  logic               commit,
   input  logic               clear_halt,
   input  logic               pc_write_normal,
   input  logic               reg_write_normal,
   input  logic               mem_write_normal,
   input  logic [XLEN-1:0]    pc_current,
   input  logic [XLEN-1:0]    pc_saved,
   output logic               pc_write_out,
   output logic               reg_write_out,
   output logic               mem_write_out,
   output logic [XLEN-1:0]    pc_next,
   output logic               insert_nop,
   output logic               retry_en,
   output logic               halted,
   output logic               trap_req,
   output logic [3:0]         fault_cause,
   output logic [3:0]         retry_cnt
`ifdef FT_FAULT_LOG_EN
   ,
   output logic [15:0]        fault_total,
   output logic [NUM_SRC-1:0] sticky_src
`endif
);

   localparam logic [3:0] MAX_RETRY_C  = 4'(MAX_RETRY);
   localparam logic [3:0] FLUSH_LAST_C = 4'(FLUSH_CYCLES - 1);

   state_e       r_state;
   state_e       w_next_state;
   logic [3:0]   r_flush_cnt;
   logic [3:0]   r_retry_cnt;
   logic [3:0]   r_fault_cause;
   logic         r_halt_entry;
   logic         r_active;

   logic         w_fault_valid;
   logic [3:0]   w_fault_idx;
   logic         w_fault_take;
   logic         w_flush_done;
   logic         w_retry_inc;
   logic         w_retry_clr;
   logic         w_pc_wr;
   logic         w_reg_wr;
   logic         w_mem_wr;

   ft_fault_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio_enc (
      .fault_vec (fault_vec),
      .valid     (w_fault_valid),
      .index     (w_fault_idx)
   );

   assign w_flush_done = (r_flush_cnt == FLUSH_LAST_C);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_NORMAL;
      else          r_state <= w_next_state;
   end

   // NOTE: every output is given a default first so no path through the case infers a latch.
   always_comb begin
      w_next_state = r_state;
      w_fault_take = 1'b0;
      w_retry_inc  = 1'b0;
      w_retry_clr  = 1'b0;
      w_pc_wr      = 1'b0;
      w_reg_wr     = 1'b0;
      w_mem_wr     = 1'b0;
      pc_next      = pc_current;
      insert_nop   = 1'b0;
      retry_en     = 1'b0;
      halted       = 1'b0;
      trap_req     = 1'b0;
      case (r_state)
         ST_NORMAL: begin
            if (w_fault_valid) begin
               w_fault_take = 1'b1;
               w_next_state = ST_FLUSH;
            end else begin
               w_pc_wr  = pc_write_normal;
               w_reg_wr = reg_write_normal;
               w_mem_wr = mem_write_normal;
            end
         end
         ST_FLUSH: begin
            insert_nop = 1'b1;
            if (w_flush_done)
               w_next_state = (r_retry_cnt < MAX_RETRY_C) ? ST_RETRY : ST_HALT;
         end
         ST_RETRY: begin
            pc_next      = pc_saved;
            w_pc_wr      = 1'b1;
            retry_en     = 1'b1;
            w_retry_inc  = 1'b1;
            w_next_state = ST_WAIT_COMMIT;
         end
         ST_WAIT_COMMIT: begin
            // A fault wins over a simultaneous commit.
            if (w_fault_valid) begin
               w_fault_take = 1'b1;
               w_next_state = ST_FLUSH;
            end else begin
               w_pc_wr  = pc_write_normal;
               w_reg_wr = reg_write_normal;
               w_mem_wr = mem_write_normal;
               if (commit) begin
                  w_retry_clr  = 1'b1;
                  w_next_state = ST_NORMAL;
               end
            end
         end
         ST_HALT: begin
            insert_nop = 1'b1;
            halted     = 1'b1;
            if (r_halt_entry) begin
               trap_req = 1'b1;
               pc_next  = TRAP_VEC;
               w_pc_wr  = 1'b1;
            end
            if (clear_halt) begin
               w_retry_clr  = 1'b1;
               w_next_state = ST_NORMAL;
            end
         end
         default: w_next_state = ST_NORMAL;
      endcase
   end

   // r_active holds writes low through reset and until the first edge after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active      <= 1'b0;
         r_flush_cnt   <= '0;
         r_retry_cnt   <= '0;
         r_fault_cause <= '0;
         r_halt_entry  <= 1'b0;
      end else begin
         r_active     <= 1'b1;
         r_halt_entry <= (w_next_state == ST_HALT) && (r_state != ST_HALT);
         if (r_state == ST_FLUSH && !w_flush_done) r_flush_cnt <= r_flush_cnt + 4'd1;
         else                                      r_flush_cnt <= '0;
         if (w_retry_clr)                                      r_retry_cnt <= '0;
         else if (w_retry_inc && r_retry_cnt < MAX_RETRY_C)    r_retry_cnt <= r_retry_cnt + 4'd1;
         if (w_fault_take) r_fault_cause <= w_fault_idx;
      end
   end

   assign pc_write_out  = w_pc_wr  & r_active;
   assign reg_write_out = w_reg_wr & r_active;
   assign mem_write_out = w_mem_wr & r_active;
   assign fault_cause   = r_fault_cause;
   assign retry_cnt     = r_retry_cnt;

`ifdef FT_FAULT_LOG_EN
   logic [15:0]        r_fault_total;
   logic [NUM_SRC-1:0] r_sticky_src;
   logic [NUM_SRC-1:0] w_fault_onehot;

   // Isolating the lowest set bit gives the one-hot form of the encoded source.
   assign w_fault_onehot = fault_vec & (~fault_vec + NUM_SRC'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fault_total <= '0;
         r_sticky_src  <= '0;
      end else if (w_fault_take) begin
         if (r_fault_total != 16'hFFFF) r_fault_total <= r_fault_total + 16'd1;
         r_sticky_src <= r_sticky_src | w_fault_onehot;
      end
   end

   assign fault_total = r_fault_total;
   assign sticky_src  = r_sticky_src;
`endif

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Directed bench for fault_recovery_ctrl: default build plus a MAX_RETRY=0 instance.
// Logging outputs are checked only when FT_FAULT_LOG_EN is defined.
module tb_fault_recovery_ctrl;

   logic        clk;
   logic        reset_n;
   logic [3:0]  fault_vec;
   logic [3:0]  fault_vec0;
   logic        commit;
   logic        clear_halt;
   logic        pc_write_normal;
   logic        reg_write_normal;
   logic        mem_write_normal;
   logic [31:0] pc_current;
   logic [31:0] pc_saved;

   logic        pc_write_out, reg_write_out, mem_write_out;
   logic [31:0] pc_next;
   logic        insert_nop, retry_en, halted, trap_req;
   logic [3:0]  fault_cause, retry_cnt;

   logic        d0_pc_write_out, d0_reg_write_out, d0_mem_write_out;
   logic [31:0] d0_pc_next;
   logic        d0_insert_nop, d0_retry_en, d0_halted, d0_trap_req;
   logic [3:0]  d0_fault_cause, d0_retry_cnt;

`ifdef FT_FAULT_LOG_EN
   logic [15:0] fault_total, d0_fault_total;
   logic [3:0]  sticky_src, d0_sticky_src;
`endif

   int n_vec;
   int n_miss;

   fault_recovery_ctrl u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .fault_vec        (fault_vec),
      .commit           (commit),
      .clear_halt       (clear_halt),
      .pc_write_normal  (pc_write_normal),
      .reg_write_normal (reg_write_normal),
      .mem_write_normal (mem_write_normal),
      .pc_current       (pc_current),
      .pc_saved         (pc_saved),
      .pc_write_out     (pc_write_out),
      .reg_write_out    (reg_write_out),
      .mem_write_out    (mem_write_out),
      .pc_next          (pc_next),
      .insert_nop       (insert_nop),
      .retry_en         (retry_en),
      .halted           (halted),
      .trap_req         (trap_req),
      .fault_cause      (fault_cause),
      .retry_cnt        (retry_cnt)
`ifdef FT_FAULT_LOG_EN
      ,
      .fault_total      (fault_total),
      .sticky_src       (sticky_src)
`endif
   );

   fault_recovery_ctrl #(
      .MAX_RETRY (0)
   ) u_dut0 (
      .clk              (clk),
      .reset_n          (reset_n),
      .fault_vec        (fault_vec0),
      .commit           (commit),
      .clear_halt       (clear_halt),
      .pc_write_normal  (pc_write_normal),
      .reg_write_normal (reg_write_normal),
      .mem_write_normal (mem_write_normal),
      .pc_current       (pc_current),
      .pc_saved         (pc_saved),
      .pc_write_out     (d0_pc_write_out),
      .reg_write_out    (d0_reg_write_out),
      .mem_write_out    (d0_mem_write_out),
      .pc_next          (d0_pc_next),
      .insert_nop       (d0_insert_nop),
      .retry_en         (d0_retry_en),
      .halted           (d0_halted),
      .trap_req         (d0_trap_req),
      .fault_cause      (d0_fault_cause),
      .retry_cnt        (d0_retry_cnt)
`ifdef FT_FAULT_LOG_EN
      ,
      .fault_total      (d0_fault_total),
      .sticky_src       (d0_sticky_src)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive inputs on the falling edge, then let combinational outputs settle.
   task automatic cyc(input logic [3:0] fv, input logic cm, input logic ch, input logic [3:0] fv0);
      @(negedge clk);
      fault_vec  = fv;
      commit     = cm;
      clear_halt = ch;
      fault_vec0 = fv0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec            = 0;
      n_miss           = 0;
      reset_n          = 1'b0;
      fault_vec        = '0;
      fault_vec0       = '0;
      commit           = 1'b0;
      clear_halt       = 1'b0;
      pc_write_normal  = 1'b1;
      reg_write_normal = 1'b1;
      mem_write_normal = 1'b1;
      pc_current       = 32'h40;
      pc_saved         = 32'h08;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_pc_wr",     32'(pc_write_out),  0);
      check("rst_reg_wr",    32'(reg_write_out), 0);
      check("rst_mem_wr",    32'(mem_write_out), 0);
      check("rst_halted",    32'(halted),        0);
      check("rst_nop",       32'(insert_nop),    0);
      check("rst_retry_cnt", 32'(retry_cnt),     0);
      check("rst_cause",     32'(fault_cause),   0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single fault, retry, commit
      cyc(4'h0, 0, 0, 4'h0);
      check("a_pass_pc_wr",  32'(pc_write_out),  1);
      check("a_pass_reg_wr", 32'(reg_write_out), 1);
      check("a_pass_mem_wr", 32'(mem_write_out), 1);
      check("a_pass_pc",     pc_next,            32'h40);
      cyc(4'b0100, 0, 0, 4'h0);
      check("a_gate_pc_wr",  32'(pc_write_out),  0);
      check("a_gate_reg_wr", 32'(reg_write_out), 0);
      check("a_gate_mem_wr", 32'(mem_write_out), 0);
      cyc(4'h0, 0, 0, 4'h0);
      check("a_f1_nop",      32'(insert_nop),    1);
      check("a_f1_cause",    32'(fault_cause),   2);
      check("a_f1_pc_wr",    32'(pc_write_out),  0);
      cyc(4'h0, 0, 0, 4'h0);
      check("a_f2_nop",      32'(insert_nop),    1);
      check("a_f2_retry_en", 32'(retry_en),      0);
      cyc(4'h0, 0, 0, 4'h0);
      check("a_rt_retry_en", 32'(retry_en),      1);
      check("a_rt_pc",       pc_next,            32'h08);
      check("a_rt_pc_wr",    32'(pc_write_out),  1);
      check("a_rt_reg_wr",   32'(reg_write_out), 0);
      check("a_rt_mem_wr",   32'(mem_write_out), 0);
      check("a_rt_nop",      32'(insert_nop),    0);
      cyc(4'h0, 0, 0, 4'h0);
      check("a_wc_cnt",      32'(retry_cnt),     1);
      check("a_wc_reg_wr",   32'(reg_write_out), 1);
      check("a_wc_retry_en", 32'(retry_en),      0);
      cyc(4'h0, 1, 0, 4'h0);
      cyc(4'h0, 0, 0, 4'h0);
      check("a_nrm_cnt",     32'(retry_cnt),     0);
      check("a_nrm_pc_wr",   32'(pc_write_out),  1);

      // Repeated faults: priority, fault during flush, fault+commit, retries exhausted -> HALT
      cyc(4'b1010, 0, 0, 4'h0);
      check("b_gate_pc_wr",  32'(pc_write_out),  0);
      cyc(4'b0001, 0, 0, 4'h0);
      check("b_f1_cause",    32'(fault_cause),   1);
      check("b_f1_nop",      32'(insert_nop),    1);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_f2_nop",      32'(insert_nop),    1);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_rt1_en",      32'(retry_en),      1);
      check("b_rt1_cause",   32'(fault_cause),   1);
      cyc(4'b0100, 1, 0, 4'h0);
      check("b_wc1_cnt",     32'(retry_cnt),     1);
      check("b_wc1_gate",    32'(pc_write_out),  0);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_f_cause2",    32'(fault_cause),   2);
      check("b_f_nop",       32'(insert_nop),    1);
      check("b_f_cnt_kept",  32'(retry_cnt),     1);
      cyc(4'h0, 0, 0, 4'h0);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_rt2_en",      32'(retry_en),      1);
      cyc(4'b0001, 0, 0, 4'h0);
      check("b_wc2_cnt",     32'(retry_cnt),     2);
      cyc(4'h0, 0, 0, 4'h0);
      cyc(4'h0, 0, 0, 4'h0);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_rt3_en",      32'(retry_en),      1);
      cyc(4'b1000, 0, 0, 4'h0);
      check("b_wc3_cnt",     32'(retry_cnt),     3);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_f_cause3",    32'(fault_cause),   3);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_f2_no_rt",    32'(retry_en),      0);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_h_trap",      32'(trap_req),      1);
      check("b_h_pc",        pc_next,            32'h100);
      check("b_h_pc_wr",     32'(pc_write_out),  1);
      check("b_h_reg_wr",    32'(reg_write_out), 0);
      check("b_h_halted",    32'(halted),        1);
      check("b_h_nop",       32'(insert_nop),    1);
      check("b_h_retry_en",  32'(retry_en),      0);
      cyc(4'b0001, 0, 0, 4'h0);
      check("b_h2_trap",     32'(trap_req),      0);
      check("b_h2_pc_wr",    32'(pc_write_out),  0);
      check("b_h2_halted",   32'(halted),        1);
      check("b_h2_cause",    32'(fault_cause),   3);
      cyc(4'h0, 0, 1, 4'h0);
      check("b_h3_halted",   32'(halted),        1);
      cyc(4'h0, 0, 0, 4'h0);
      check("b_clr_halted",  32'(halted),        0);
      check("b_clr_cnt",     32'(retry_cnt),     0);
      check("b_clr_pc_wr",   32'(pc_write_out),  1);
      check("b_clr_pc",      pc_next,            32'h40);
`ifdef FT_FAULT_LOG_EN
      check("log_total",     32'(fault_total),   5);
      check("log_sticky",    32'(sticky_src),    32'hF);
`endif

      // MAX_RETRY=0 instance goes straight to HALT; reset during its HALT and main FLUSH
      cyc(4'h0, 0, 0, 4'b0100);
      check("z_gate_pc_wr",  32'(d0_pc_write_out), 0);
      cyc(4'h0, 0, 0, 4'h0);
      check("z_f1_nop",      32'(d0_insert_nop),   1);
      check("z_f1_cause",    32'(d0_fault_cause),  2);
      cyc(4'h0, 0, 0, 4'h0);
      check("z_f2_no_rt",    32'(d0_retry_en),     0);
      cyc(4'b0010, 0, 0, 4'h0);
      check("z_h_trap",      32'(d0_trap_req),     1);
      check("z_h_pc",        d0_pc_next,           32'h100);
      check("z_h_retry_en",  32'(d0_retry_en),     0);
      check("z_h_halted",    32'(d0_halted),       1);
      cyc(4'h0, 0, 0, 4'h0);
      check("z_h2_trap",     32'(d0_trap_req),     0);
      check("z_h2_halted",   32'(d0_halted),       1);
      check("c_f1_nop",      32'(insert_nop),      1);
      check("c_f1_cause",    32'(fault_cause),     1);
`ifdef FT_FAULT_LOG_EN
      check("z_log_total",   32'(d0_fault_total),  1);
      check("z_log_sticky",  32'(d0_sticky_src),   32'h4);
`endif
      #2;
      reset_n = 1'b0;
      #1;
      check("c_rst_nop",     32'(insert_nop),      0);
      check("c_rst_pc_wr",   32'(pc_write_out),    0);
      check("c_rst_cause",   32'(fault_cause),     0);
      check("c_rst_cnt",     32'(retry_cnt),       0);
      check("c_rst_retry",   32'(retry_en),        0);
      check("z_rst_halted",  32'(d0_halted),       0);
      check("z_rst_trap",    32'(d0_trap_req),     0);
      check("z_rst_nop",     32'(d0_insert_nop),   0);
      check("z_rst_cause",   32'(d0_fault_cause),  0);
`ifdef FT_FAULT_LOG_EN
      check("log_rst_total", 32'(fault_total),     0);
      check("log_rst_stky",  32'(sticky_src),      0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      cyc(4'h0, 0, 0, 4'h0);
      check("c_rel_pc_wr",   32'(pc_write_out),    1);
      check("c_rel_nop",     32'(insert_nop),      0);
      check("z_rel_pc_wr",   32'(d0_pc_write_out), 1);
      check("z_rel_halted",  32'(d0_halted),       0);

      // Flush counter restarts from zero after a mid-flush reset
      cyc(4'b0100, 0, 0, 4'h0);
      cyc(4'h0, 0, 0, 4'h0);
      check("d_f1_nop",      32'(insert_nop),      1);
      cyc(4'h0, 0, 0, 4'h0);
      check("d_f2_nop",      32'(insert_nop),      1);
      cyc(4'h0, 0, 0, 4'h0);
      check("d_rt_en",       32'(retry_en),        1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
